// File: rtl/tachometer_pulse_generator.sv
// Tachometer plant model: commanded RPM -> slew-limited speed -> 360 PPR square wave.
// Latency: speed steps once per ramp tick; pulse_out follows the accumulator MSB by 1 clock.
// Backpressure: none; free-running generator, inputs sampled every cycle.
//
// Ports:
//   clk_in           - core clock (125 MHz nominal)
//   reset_in         - synchronous active-high reset, clears all state
//   enable_in        - low forces the effective target to 0 (coast down at ramp rate)
//   target_rpm_in    - commanded speed, clamped to MAX_RPM
//   pulse_out        - registered tachometer square wave
//   current_rpm_out  - registered ramped model speed
//   at_target_out    - registered flag: model speed equals effective target
//   pulse_count_out  - rising edges of pulse_out since reset, wraps at 16 bits
module tachometer_pulse_generator #(
    parameter int ACC_WIDTH         = 32,
    parameter int PHASE_INC_PER_RPM = 206,
    parameter int MAX_RPM           = 500,
    parameter int RAMP_DIVISOR      = 125000,
    parameter int RAMP_STEP         = 5
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        enable_in,
    input  logic [8:0]  target_rpm_in,
    output logic        pulse_out,
    output logic [8:0]  current_rpm_out,
    output logic        at_target_out,
    output logic [15:0] pulse_count_out
);

    localparam int                   TMR_W    = (RAMP_DIVISOR > 1) ? $clog2(RAMP_DIVISOR) : 1;
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(RAMP_DIVISOR - 1);
    localparam logic [8:0]           MAX_L    = 9'(MAX_RPM);
    localparam logic [8:0]           STEP_L   = 9'(RAMP_STEP);
    localparam logic [7:0]           INC_L    = 8'(PHASE_INC_PER_RPM);

    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 ramp_tick;
    logic [8:0]           eff;
    logic [8:0]           diff;
    logic [8:0]           current_q, current_d;
    logic [16:0]          phase_prod;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 pulse_q, pulse_d;
    logic [15:0]          count_q, count_d;
    logic                 at_target_q, at_target_d;

    always_comb begin
        // Effective target: forced to zero when disabled, else clamped.
        eff = 9'd0;
        if (enable_in) begin
            eff = (target_rpm_in > MAX_L) ? MAX_L : target_rpm_in;
        end

        // Free-running ramp timer; target changes never restart it.
        ramp_tick = (timer_q == TMR_LAST);
        timer_d   = ramp_tick ? '0 : timer_q + 1'b1;

        // Slew limiter: step toward eff by at most STEP_L, never past it.
        current_d = current_q;
        diff      = 9'd0;
        if (ramp_tick) begin
            if (current_q < eff) begin
                diff      = eff - current_q;
                current_d = current_q + ((diff < STEP_L) ? diff : STEP_L);
            end else if (current_q > eff) begin
                diff      = current_q - eff;
                current_d = current_q - ((diff < STEP_L) ? diff : STEP_L);
            end
        end

        // Full 17-bit product, zero-extended before the add. A zero speed
        // adds nothing, which freezes the accumulator and thus pulse_out.
        phase_prod = {8'd0, current_q} * {9'd0, INC_L};
        acc_d      = acc_q + ACC_WIDTH'(phase_prod);

        pulse_d     = acc_q[ACC_WIDTH-1];
        count_d     = (pulse_d && !pulse_q) ? count_q + 16'd1 : count_q;
        at_target_d = (current_d == eff);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            timer_q     <= '0;
            current_q   <= 9'd0;
            acc_q       <= '0;
            pulse_q     <= 1'b0;
            count_q     <= 16'd0;
            at_target_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            current_q   <= current_d;
            acc_q       <= acc_d;
            pulse_q     <= pulse_d;
            count_q     <= count_d;
            at_target_q <= at_target_d;
        end
    end

    assign pulse_out       = pulse_q;
    assign current_rpm_out = current_q;
    assign at_target_out   = at_target_q;
    assign pulse_count_out = count_q;

endmodule

// File: doc/tachometer_pulse_generator.md
# tachometer_pulse_generator

Emulates the motor's optical tachometer. It converts a commanded RPM into a 360-pulses-per-revolution square wave on a single wire. A slew-rate limiter models motor inertia. The block serves as a plant stand-in for hardware-in-loop and simulation of the wall-follower speed loop: its `pulse_out` drives the tachometer pulse input of the RPM measurement block, closing the loop without a physical motor.

## Interface
Parameters:
- `ACC_WIDTH`, 32: phase accumulator width in bits.
- `PHASE_INC_PER_RPM`, 206: accumulator increment per clock per RPM. This is round(6 · 2^32 / 125e6), with about 0.08 % frequency error at 125 MHz.
- `MAX_RPM`, 500: targets above this value are clamped to it.
- `RAMP_DIVISOR`, 125000: clocks per ramp tick (1 ms at 125 MHz).
- `RAMP_STEP`, 5: maximum RPM change per ramp tick.

Ports:
- `clk_in`, input, 1: 125 MHz clock.
- `reset_in`, input, 1: reset, synchronous, active-high.
- `enable_in`, input, 1: when low, the effective target is 0 and the model coasts down at the ramp rate.
- `target_rpm_in`, input, 9: commanded speed, sampled every cycle.
- `pulse_out`, output, 1: tachometer square wave, registered.
- `current_rpm_out`, output, 9: ramped model speed, registered.
- `at_target_out`, output, 1: high when `current_rpm_out` equals the effective target, registered.
- `pulse_count_out`, output, 16: count of `pulse_out` rising edges since reset; wraps 65535 → 0.

## Operation
- Effective target:
  - `eff = 0` if `enable_in == 0`.
  - Otherwise `eff = min(target_rpm_in, MAX_RPM)`.
- Ramp timer:
  - Counts 0 … `RAMP_DIVISOR-1` and generates `ramp_tick` at the terminal count.
  - Free-running; it is not restarted by target changes.
- On `ramp_tick`:
  - If `current < eff`: `current += min(RAMP_STEP, eff - current)`.
  - If `current > eff`: `current -= min(RAMP_STEP, current - eff)`.
  - Otherwise `current` is held. It never overshoots `eff`.
- Target changes mid-ramp take effect at the next tick. The ramp uses whichever `eff` is present on the tick cycle.
- Phase accumulator, updated every clock:
  - `acc <= acc + current * PHASE_INC_PER_RPM`, modulo 2^`ACC_WIDTH`.
  - The product is computed at full width: 9 + 8 bits, zero-extended to `ACC_WIDTH`. It is not truncated before the add.
- `pulse_out <= acc[ACC_WIDTH-1]`. This gives a 50 % duty square wave at f = `current` · `PHASE_INC_PER_RPM` · 125e6 / 2^32 ≈ 6 · `current` Hz (360 pulses/rev).
- When `current == 0`, `acc` is frozen and `pulse_out` holds its last level. No edges are produced.
- Edge counter: `pulse_count_out` increments on cycles where the new `pulse_out` is 1 and the old `pulse_out` is 0.
- `at_target_out <= (current_next == eff)`, evaluated each cycle.
- Receiver compatibility:
  - At `MAX_RPM` = 500 the period is about 41,700 clocks, so each half-period is about 20,850 clocks.
  - This exceeds the 12,500-clock (10 kHz) sampling period of the measurement block, so every pulse is observable.
  - `MAX_RPM` must not be raised above 833.

## Timing
- Reset values: `acc`, ramp timer, `current_rpm_out`, `pulse_out`, `pulse_count_out` and `at_target_out` are all 0.
- The first rising edge of `clk_in` with `reset_in` high clears all state. This applies mid-ramp and mid-pulse as well; a high `pulse_out` drops to 0 on the next cycle.
- Latency of `current_rpm_out` from a target change: 1 to `RAMP_DIVISOR` clocks until the first step, then one step per tick.
- Latency of `pulse_out`: `acc` MSB toggle → `pulse_out` in 1 clock. `pulse_count_out` updates in the same cycle `pulse_out` rises.
- Enable deassert: `eff` becomes 0 in the same cycle. The decay begins at the next `ramp_tick`.
- Ramp and accumulator run concurrently. A `current` change is used by the accumulator on the following cycle.

## Test plan
1. Reset with `target_rpm_in = 300`, `enable_in = 1`:
   - Required: all outputs 0 during reset.
   - Required: `current_rpm_out` reaches 300 after exactly 60 ticks (60 · `RAMP_DIVISOR` clocks, ± timer phase), then `at_target_out` = 1.
2. Steady 300 RPM, with `RAMP_DIVISOR` = 10 for simulation speed:
   - Required: period between `pulse_out` rising edges is 69,497 or 69,498 clocks.
   - Required: high time is within ±1 clock of the low time.
3. Target 600 → `current_rpm_out` saturates at 500. Target 3 from `current` = 0 → one tick yields 3 (no overshoot).
4. `enable_in` dropped at 200 RPM:
   - Required: `current_rpm_out` decreases by 5 per tick to 0 after 40 ticks.
   - Required: `pulse_out` then freezes and `pulse_count_out` stops.
5. Assert `reset_in` for 1 cycle while `pulse_out` = 1 and `current` = 250 → next cycle `pulse_out` = 0, `current_rpm_out` = 0, `pulse_count_out` = 0.
6. Loopback into the tachometer RPM measurement block at a steady 300 RPM:
   - Required: reported RPM is within 300 ± 17 (one pulse per 10 ms window) on every window after settling.
   - Required: `pulse_count_out` wraps from 65535 to 0 without glitching `pulse_out`.
